serial_logic_unit: RTL and testbench

SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

---
 rtl/slu_pkg.sv | 22 ++
 rtl/slu_bit_gate.sv | 28 ++
 rtl/serial_logic_unit.sv | 130 +++++++++++++
 tb/tb_serial_logic_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/slu_pkg.sv
// Shared types for the serial logic unit: opcode and FSM state encodings, default width.
// Pure declarations; no logic, latency or backpressure of its own.
package slu_pkg;

    localparam int SLU_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NOR  = 3'd4,
        OP_NAND = 3'd5
    } slu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } slu_state_e;

endpackage

// File: rtl/slu_bit_gate.sv
// One-bit logic evaluator; flags opcodes 6-7 as illegal.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module slu_bit_gate
    import slu_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a_bit,
    input  logic       b_bit,
    output logic       y_bit,
    output logic       illegal
);

    always_comb begin
        y_bit   = 1'b0;
        illegal = 1'b0;
        case (slu_op_e'(op))
            OP_NOT:  y_bit = ~a_bit;
            OP_AND:  y_bit = a_bit & b_bit;
            OP_OR:   y_bit = a_bit | b_bit;
            OP_XOR:  y_bit = a_bit ^ b_bit;
            OP_NOR:  y_bit = ~(a_bit | b_bit);
            OP_NAND: y_bit = ~(a_bit & b_bit);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial bitwise logic unit, LSB first; SERIAL_LOGIC_UNIT_PARITY_EN adds a parity output.
// Latency: WIDTH+1 cycles handshake-to-out_valid for legal ops, 1 cycle for illegal ops.
// Backpressure: single operation in flight; in_ready only in IDLE, result held until out_ready.
module serial_logic_unit
    import slu_pkg::*;
#(
    parameter int WIDTH = SLU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
    output logic             busy,
    output logic             parity
`else
    output logic             busy
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    slu_state_e       state;
    slu_state_e       state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic [2:0]       gate_op;
    logic             gate_y;
    logic             gate_illegal;
    logic             accept;
    logic             last_bit;

    // The single gate checks the incoming opcode in IDLE and evaluates bits in BUSY.
    assign gate_op  = (state == ST_BUSY) ? op_q : op;
    assign accept   = in_valid && (state == ST_IDLE);
    assign last_bit = (state == ST_BUSY) && (cnt == CNT_LAST);

    slu_bit_gate u_gate (
        .op      (gate_op),
        .a_bit   (a_q[0]),
        .b_bit   (b_q[0]),
        .y_bit   (gate_y),
        .illegal (gate_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = gate_illegal ? ST_DONE : ST_BUSY;
            ST_BUSY: if (cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cnt   <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            if (gate_illegal) begin
                res_q <= '0;
                err_q <= 1'b1;
            end else begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op;
                err_q <= 1'b0;
            end
        end else if (state == ST_BUSY) begin
            // Operands shift right so bit i reaches the gate on BUSY cycle i.
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= {gate_y, res_q[WIDTH-1:1]};
            if (!last_bit) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if ((state == ST_DONE) && out_ready) begin
            err_q <= 1'b0;
        end
    end

`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= 1'b0;
        end else if (last_bit) begin
            parity_q <= ^{gate_y, res_q[WIDTH-1:1]};
        end
    end

    assign parity = parity_q;
`endif

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_BUSY);
    assign out_valid = (state == ST_DONE);
    assign result    = res_q;
    assign err       = err_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Bench for serial_logic_unit (WIDTH=8): directed operations plus a cycle-level reference model.
// Define SERIAL_LOGIC_UNIT_PARITY_EN to also check the parity output.
module tb_serial_logic_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         err;
    logic         busy;
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
    logic         parity;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_logic_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
        .busy      (busy),
        .parity    (parity)
`else
        .busy      (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input int o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            0:       return ~x;
            1:       return x & y;
            2:       return x | y;
            3:       return x ^ y;
            4:       return ~(x | y);
            5:       return ~(x & y);
            default: return '0;
        endcase
    endfunction

    // Reference model: countdown of remaining busy cycles and a pending-result flag.
    int           m_left = 0;
    bit           m_done = 0;
    bit           m_live = 0;
    logic [W-1:0] m_res  = '0;
    logic         m_err  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 0;
            m_res  = '0;
            m_err  = 1'b0;
            m_live = 1;
        end else if (m_done) begin
            if (out_ready) m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1;
        end else if (in_valid) begin
            if (int'(op) > 5) begin
                m_done = 1;
                m_res  = '0;
                m_err  = 1'b1;
            end else begin
                m_left = W;
                m_res  = ref_op(int'(op), a, b);
                m_err  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_in_ready",  in_ready,  (!m_done && m_left == 0));
            chk("m_busy",      busy,      (m_left > 0));
            chk("m_out_valid", out_valid, m_done);
            if (m_done) begin
                chk("m_result", result, m_res);
                chk("m_err",    err,    m_err);
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
                chk("m_parity", parity, m_err ? 1'b0 : ^m_res);
`endif
            end else begin
                chk("m_err_idle", err, 1'b0);
            end
        end
    end

    // Issues one operation from an idle DUT; leaves the bench #1 after an edge with the DUT idle.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int hold, input logic [W-1:0] exp_res, input logic exp_err,
                         input logic exp_par, input int exp_lat, input string nm);
        int lat;
        int nbusy;
        nbusy     = 0;
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 64) begin
            if (busy === 1'b1) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_busy_cycles"}, nbusy, exp_lat - 1);
        chk({nm, "_result"}, result, exp_res);
        chk({nm, "_err"}, err, exp_err);
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
        chk({nm, "_parity"}, parity, exp_par);
`else
        if (exp_par === 1'bx) $display("note: unexpected parity literal in %s", nm);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op       = 3'd3;
            a        = 8'h55;
            b        = 8'hAA;
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, out_valid, 1'b1);
            chk({nm, "_hold_result"}, result, exp_res);
            chk({nm, "_hold_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({nm, "_after_in_ready"}, in_ready, 1'b1);
        chk({nm, "_after_out_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result",    result,    8'h00);
        chk("rst_err",       err,       1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", in_ready, 1'b1);

        do_op(3'd1, 8'hF0, 8'h3C, 0, 8'h30, 1'b0, 1'b0, 9, "and");
        do_op(3'd0, 8'hA5, 8'hFF, 0, 8'h5A, 1'b0, 1'b0, 9, "not");
        do_op(3'd2, 8'h0F, 8'h10, 5, 8'h1F, 1'b0, 1'b1, 9, "or_hold");
        do_op(3'd7, 8'h12, 8'h34, 0, 8'h00, 1'b1, 1'b0, 1, "illegal7");
        do_op(3'd6, 8'hFF, 8'hFF, 2, 8'h00, 1'b1, 1'b0, 1, "illegal6");
        do_op(3'd5, 8'hC3, 8'hA5, 0, 8'h7E, 1'b0, 1'b0, 9, "nand");
        do_op(3'd4, 8'h81, 8'h18, 0, 8'h66, 1'b0, 1'b0, 9, "nor");

        // Reset in the middle of a NAND must abandon it without a result.
        in_valid  = 1'b1;
        op        = 3'd5;
        a         = 8'hF0;
        b         = 8'h0F;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstbusy_busy_c4", busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstbusy_out_valid", out_valid, 1'b0);
        chk("rstbusy_busy",      busy,      1'b0);
        chk("rstbusy_result",    result,    8'h00);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("rstbusy_in_ready", in_ready, 1'b1);

        do_op(3'd3, 8'hFF, 8'h01, 0, 8'hFE, 1'b0, 1'b1, 9, "xor");
        do_op(3'd4, 8'hFF, 8'h00, 0, 8'h00, 1'b0, 1'b0, 9, "nor_zero");
        do_op(3'd3, 8'h01, 8'h00, 3, 8'h01, 1'b0, 1'b1, 9, "xor_lsb");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
